// File: rtl/l2_bank_arbiter_if.sv
// Request/response bundle between the L2 masters and the word-interleaved banks.
// The arbiter sits on the slave modport; whoever drives the masters and models the banks uses master.
interface l2_bank_arbiter_if #(
    parameter int NB_MASTERS = 4,
    parameter int NB_BANKS   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [NB_MASTERS-1:0]                 m_req_i;
    logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i;
    logic [NB_MASTERS-1:0]                 m_wen_i;
    logic [NB_MASTERS-1:0][31:0]           m_wdata_i;
    logic [NB_MASTERS-1:0][3:0]            m_be_i;
    logic [NB_MASTERS-1:0]                 m_gnt_o;
    logic [NB_MASTERS-1:0]                 m_r_valid_o;
    logic [NB_MASTERS-1:0][31:0]           m_r_rdata_o;

    logic [NB_BANKS-1:0]                   b_req_o;
    logic [NB_BANKS-1:0][ADDR_WIDTH-1:0]   b_add_o;
    logic [NB_BANKS-1:0]                   b_wen_o;
    logic [NB_BANKS-1:0][31:0]             b_wdata_o;
    logic [NB_BANKS-1:0][3:0]              b_be_o;
    logic [NB_BANKS-1:0]                   b_gnt_i;
    logic [NB_BANKS-1:0][31:0]             b_r_rdata_i;

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, b_gnt_i, b_r_rdata_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, b_req_o, b_add_o, b_wen_o, b_wdata_o, b_be_o
    );

    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, b_gnt_i, b_r_rdata_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, b_req_o, b_add_o, b_wen_o, b_wdata_o, b_be_o
    );
endinterface

// File: rtl/l2_bank_arbiter.sv
// N-master to M-bank word-interleaved L2 crossbar with per-bank round-robin arbitration and 1-cycle responses.
// Optional: define L2_BANK_ARB_PERF_CNT_EN to add per-bank saturating conflict counters (conflict_cnt_o).
module l2_bank_arbiter #(
    parameter int NB_MASTERS = 4,
    parameter int NB_BANKS   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    l2_bank_arbiter_if.slave          l2_bus
`ifdef L2_BANK_ARB_PERF_CNT_EN
    ,
    output logic [NB_BANKS-1:0][31:0] conflict_cnt_o
`endif
);
    localparam int MW = $clog2(NB_MASTERS);
    localparam int BW = $clog2(NB_BANKS);
    localparam logic [NB_MASTERS-1:0] ONE_M = {{(NB_MASTERS-1){1'b0}}, 1'b1};

    logic [NB_BANKS-1:0][NB_MASTERS-1:0] w_gnt_mat;
    logic [NB_BANKS-1:0]                 w_valid;
    logic [NB_BANKS-1:0][MW-1:0]         w_idx;

    for (genvar gi = 0; gi < NB_BANKS; gi++) begin : g_bank
        logic [NB_MASTERS-1:0] w_tgt;
        logic [MW-1:0]         w_win;
        logic                  w_any;
        logic                  w_acc;
        logic [MW-1:0]         r_ptr;
        logic [MW-1:0]         r_idx;
        logic                  r_valid;

        always_comb begin
            w_tgt = '0;
            for (int m = 0; m < NB_MASTERS; m++) begin
                w_tgt[m] = l2_bus.m_req_i[m] && (l2_bus.m_add_i[m][2 +: BW] == BW'(gi));
            end
        end

        // Scan from the farthest offset down so the requester closest to r_ptr is the last to overwrite.
        always_comb begin
            w_win = r_ptr;
            for (int k = NB_MASTERS - 1; k >= 0; k--) begin
                if (w_tgt[r_ptr + MW'(k)]) begin
                    w_win = r_ptr + MW'(k);
                end
            end
        end

        assign w_any = |w_tgt;
        assign w_acc = w_any & l2_bus.b_gnt_i[gi];

        assign l2_bus.b_req_o[gi]   = w_any;
        assign l2_bus.b_add_o[gi]   = w_any ? l2_bus.m_add_i[w_win]   : '0;
        assign l2_bus.b_wen_o[gi]   = w_any ? l2_bus.m_wen_i[w_win]   : 1'b0;
        assign l2_bus.b_wdata_o[gi] = w_any ? l2_bus.m_wdata_i[w_win] : '0;
        assign l2_bus.b_be_o[gi]    = w_any ? l2_bus.m_be_i[w_win]    : '0;
        assign w_gnt_mat[gi]        = w_acc ? (ONE_M << w_win)        : '0;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ptr   <= '0;
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_acc;
                if (w_acc) begin
                    r_ptr <= w_win + MW'(1);
                    r_idx <= w_win;
                end
            end
        end

        assign w_valid[gi] = r_valid;
        assign w_idx[gi]   = r_idx;

`ifdef L2_BANK_ARB_PERF_CNT_EN
        logic [31:0] r_cnt;
        logic        w_conflict;

        // More than one bit set in the target mask means at least two masters are competing.
        assign w_conflict = (w_tgt & (w_tgt - ONE_M)) != '0;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (w_conflict && (r_cnt != 32'hFFFF_FFFF)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign conflict_cnt_o[gi] = r_cnt;
`endif
    end

    // A master has at most one response in flight, so OR-merging across banks never mixes two payloads.
    always_comb begin
        l2_bus.m_gnt_o     = '0;
        l2_bus.m_r_valid_o = '0;
        l2_bus.m_r_rdata_o = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            l2_bus.m_gnt_o = l2_bus.m_gnt_o | w_gnt_mat[b];
            if (w_valid[b]) begin
                l2_bus.m_r_valid_o[w_idx[b]] = 1'b1;
                l2_bus.m_r_rdata_o[w_idx[b]] = l2_bus.m_r_rdata_o[w_idx[b]] | l2_bus.b_r_rdata_i[b];
            end
        end
    end
endmodule
